// File: rtl/m6502_step_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : m6502_step_ctrl_pkg
// Purpose  : Shared types and constants for the 6502 step/run controller.
//            FSM state encoding and the 6502 address-bus width.
// Revision : 1.0 - initial release
// ============================================================================
package m6502_step_ctrl_pkg;

    localparam int c_ADDR_W = 16;

    typedef enum logic [2:0] {
        ST_RUN        = 3'd0,
        ST_HALT_WAIT  = 3'd1,
        ST_HALTED     = 3'd2,
        ST_STEP_FETCH = 3'd3,
        ST_STEP_EXEC  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/m6502_step_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : m6502_step_ctrl_if
// Purpose  : 6502 bus-side signals seen by the step controller.
//   cpu_en  1-clk strobe, a 6502 cycle completes this clk
//   sync    6502 SYNC (opcode fetch), valid with cpu_en
//   addr    6502 address bus, valid with cpu_en
//   rdy     to 6502 RDY, 0 stalls the CPU
//   master  : CPU side (drives cpu_en/sync/addr, receives rdy)
//   slave   : controller side
// Revision : 1.0 - initial release
// ============================================================================
interface m6502_step_ctrl_if;
    import m6502_step_ctrl_pkg::*;

    logic                cpu_en;
    logic                sync;
    logic [c_ADDR_W-1:0] addr;
    logic                rdy;

    modport master (output cpu_en, output sync, output addr, input rdy);
    modport slave  (input cpu_en, input sync, input addr, output rdy);

endinterface
`default_nettype wire

// File: rtl/m6502_step_ctrl_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Purpose  : Multi-flop synchronizer for an asynchronous level plus a
//            1-clk pulse on the synchronized 0->1 transition.
//   clk, rst_n  clock / asynchronous active-low reset
//   i_d         asynchronous input level
//   o_level     synchronized level (SYNC_STAGES clk late)
//   o_rise      1-clk pulse, same cycle o_level first reads 1
// Parameters : SYNC_STAGES (>= 2)
// Revision   : 1.0 - initial release
// ============================================================================
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/m6502_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : m6502_step_ctrl
// Purpose  : Drives 6502 RDY from the debounced run/step latch levels to give
//            free run, halt at opcode fetch and single-instruction step.
//   clk, rst_n        clock / asynchronous active-low reset
//   run_q, step_q     asynchronous latch levels (run mode, step request)
//   cpu               bus interface (slave): cpu_en, sync, addr in; rdy out
//   bp_addr, bp_valid breakpoint address / enable
//   halted            1 while the CPU is parked on an opcode fetch
//   step_count        instructions completed in step mode (wraps)
//   bp_hit            sticky breakpoint-hit flag (0 when breakpoints not built)
// Parameters : SYNC_STAGES, CNT_W
// Build macro: M6502_DB_BREAKPOINT_EN - adds the address breakpoint in RUN.
// Revision   : 1.0 - initial release
// ============================================================================
module m6502_step_ctrl
    import m6502_step_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run_q,
    input  logic                 step_q,
    m6502_step_ctrl_if.slave     cpu,
    input  logic [c_ADDR_W-1:0]  bp_addr,
    input  logic                 bp_valid,
    output logic                 halted,
    output logic [CNT_W-1:0]     step_count,
    output logic                 bp_hit
);

    logic   w_run_s;
    logic   w_run_rise_unused;
    logic   w_step_level_unused;
    logic   w_step_rise;
    logic   w_fire;
    logic   w_run_go;
    logic   w_bp_match;
    logic   w_step_done;
    logic   w_rdy;
    state_t r_state;
    state_t w_state_nxt;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_run_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (run_q),
        .o_level (w_run_s),
        .o_rise  (w_run_rise_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_d     (step_q),
        .o_level (w_step_level_unused),
        .o_rise  (w_step_rise)
    );

    // An opcode fetch completes this clk.
    assign w_fire = cpu.cpu_en & cpu.sync;

`ifdef M6502_DB_BREAKPOINT_EN
    logic r_bp_hold;
    logic r_bp_hit;

    assign w_bp_match = (r_state == ST_RUN) & w_fire & bp_valid & (cpu.addr == bp_addr);

    // A breakpoint taken while the run switch is still up must not bounce
    // straight back to RUN: hold until the switch is seen down once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bp_hold <= 1'b0;
            r_bp_hit  <= 1'b0;
        end else begin
            if (w_bp_match)
                r_bp_hold <= w_run_s;
            else if (!w_run_s)
                r_bp_hold <= 1'b0;

            if (w_bp_match)
                r_bp_hit <= 1'b1;
            else if ((r_state == ST_HALTED) && (w_state_nxt != ST_HALTED))
                r_bp_hit <= 1'b0;
        end
    end

    assign w_run_go = w_run_s & ~r_bp_hold;
    assign bp_hit   = r_bp_hit;
`else
    logic w_unused_bp;

    assign w_bp_match  = 1'b0;
    assign w_run_go    = w_run_s;
    assign bp_hit      = 1'b0;
    assign w_unused_bp = ^{cpu.addr, bp_addr, bp_valid};
`endif

    // Run request overrides every state; otherwise advance on fetch strobes.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_RUN) begin
            if (w_bp_match || !w_run_s)
                w_state_nxt = ST_HALT_WAIT;
        end else if (w_run_go) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_HALT_WAIT:  if (w_fire)      w_state_nxt = ST_HALTED;
                ST_HALTED:     if (w_step_rise) w_state_nxt = ST_STEP_FETCH;
                ST_STEP_FETCH: if (w_fire)      w_state_nxt = ST_STEP_EXEC;
                ST_STEP_EXEC:  if (w_fire)      w_state_nxt = ST_HALTED;
                default:                        w_state_nxt = ST_HALT_WAIT;
            endcase
        end
    end

    assign w_step_done = (r_state == ST_STEP_EXEC) && (w_state_nxt == ST_HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_HALT_WAIT;
            halted     <= 1'b0;
            step_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            halted  <= (w_state_nxt == ST_HALTED);
            if (w_step_done)
                step_count <= step_count + CNT_W'(1);
        end
    end

    // In the waiting states RDY drops only while SYNC is up, so the CPU
    // stalls exactly on the next opcode fetch.
    always_comb begin
        w_rdy = 1'b0;
        case (r_state)
            ST_RUN:        w_rdy = 1'b1;
            ST_HALT_WAIT:  w_rdy = ~cpu.sync;
            ST_HALTED:     w_rdy = 1'b0;
            ST_STEP_FETCH: w_rdy = 1'b1;
            ST_STEP_EXEC:  w_rdy = ~cpu.sync;
            default:       w_rdy = 1'b0;
        endcase
    end

    assign cpu.rdy = w_rdy;

endmodule
`default_nettype wire

// File: tb/tb_m6502_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_m6502_step_ctrl
// Purpose  : Self-checking bench for m6502_step_ctrl (default build).
//            A 16-bit counter and a 4-bit counter instance run side by side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m6502_step_ctrl;

    localparam int S = 2;
    // Behavioural modes of the CPU as seen from the debug panel
    localparam int MD_FREE = 0;   // CPU free running
    localparam int MD_STOP = 1;   // stop requested, next fetch gets stalled
    localparam int MD_PARK = 2;   // parked on an opcode fetch
    localparam int MD_REL  = 3;   // parked fetch being released for one step
    localparam int MD_EXEC = 4;   // stepped instruction executing

    typedef struct {
        logic r, s, e, y;
        logic x_rdy, x_halt;
        int   x_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, run_q, step_q, cpu_en, sync, bp_valid;
    logic [15:0] addr, bp_addr;
    logic        halted_a, halted_b, bp_hit_a, bp_hit_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    always #5 clk = ~clk;

    m6502_step_ctrl_if bus_a ();
    m6502_step_ctrl_if bus_b ();

    assign bus_a.cpu_en = cpu_en;
    assign bus_a.sync   = sync;
    assign bus_a.addr   = addr;
    assign bus_b.cpu_en = cpu_en;
    assign bus_b.sync   = sync;
    assign bus_b.addr   = addr;

    m6502_step_ctrl #(.SYNC_STAGES(S), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .run_q(run_q), .step_q(step_q), .cpu(bus_a.slave),
        .bp_addr(bp_addr), .bp_valid(bp_valid), .halted(halted_a),
        .step_count(cnt_a), .bp_hit(bp_hit_a)
    );

    m6502_step_ctrl #(.SYNC_STAGES(S), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .run_q(run_q), .step_q(step_q), .cpu(bus_b.slave),
        .bp_addr(bp_addr), .bp_valid(bp_valid), .halted(halted_b),
        .step_count(cnt_b), .bp_hit(bp_hit_b)
    );

    int          n_err = 0;
    int          n_chk = 0;
    int          m_mode, m_cnt;
    logic [S-1:0] m_rp;
    logic [S:0]   m_sp;
    int          cyc_clk, cpu_k;
    bit          freeze, want_rdy1;
    logic        run_v, step_v, bpv_v;
    logic [15:0] bpa_v;
    vec_t        tbl [14];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = MD_STOP;
        m_cnt  = 0;
        m_rp   = '0;
        m_sp   = '0;
    endtask

    function automatic logic model_rdy(input logic y);
        case (m_mode)
            MD_FREE, MD_REL: return 1'b1;
            MD_PARK:         return 1'b0;
            default:         return ~y;
        endcase
    endfunction

    // Called just after each active edge; uses the inputs present at that edge.
    task automatic model_update();
        logic run_s, rise, fire;
        run_s = m_rp[S-1];
        rise  = m_sp[S-1] & ~m_sp[S];
        fire  = cpu_en & sync;
        if (run_s) m_mode = MD_FREE;
        else begin
            case (m_mode)
                MD_FREE: m_mode = MD_STOP;
                MD_STOP: if (fire) m_mode = MD_PARK;
                MD_PARK: if (rise) m_mode = MD_REL;
                MD_REL:  if (fire) m_mode = MD_EXEC;
                default: if (fire) begin m_mode = MD_PARK; m_cnt++; end
            endcase
        end
        m_rp = {m_rp[S-2:0], run_q};
        m_sp = {m_sp[S-1:0], step_q};
    endtask

    task automatic check_model();
        chk("rdy", bus_a.rdy, model_rdy(sync));
        chk("rdy_w4", bus_b.rdy, model_rdy(sync));
        chk("halted", halted_a, (m_mode == MD_PARK));
        chk("count", cnt_a, m_cnt % 65536);
        chk("count_w4", cnt_b, m_cnt % 16);
        chk("bp_hit", bp_hit_a, 0);
        if (want_rdy1) chk("rdy_held_high", bus_a.rdy, 1);
    endtask

    // One clock of a 3-cycle-per-instruction CPU, a CPU cycle every 4 clk;
    // a cycle only completes if RDY allowed it.
    task automatic gen_cycle();
        logic r_before;
        @(negedge clk);
        run_q    = run_v;
        step_q   = step_v;
        bp_valid = bpv_v;
        bp_addr  = bpa_v;
        cpu_en   = (cyc_clk % 4 == 3) && !freeze;
        sync     = (cpu_k % 3 == 0);
        addr     = sync ? 16'hE000 : 16'($urandom);
        #1 check_model();
        r_before = model_rdy(sync);
        @(posedge clk);
        model_update();
        if (cpu_en && r_before) cpu_k++;
        cyc_clk++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        cpu_en = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        #1;
        chk("rst_rdy", bus_a.rdy, !sync);
        chk("rst_halted", halted_a, 0);
        chk("rst_count", cnt_a, 0);
        chk("rst_count_w4", cnt_b, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic do_step(input bit poke);
        bit left, poked;
        left  = 0;
        poked = 0;
        step_v = 1'b0;
        repeat (3) gen_cycle();
        step_v = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (m_mode != MD_PARK) left = 1;
            if (left && m_mode == MD_PARK) break;
            if (poke && !poked && m_mode == MD_EXEC) begin
                step_v = 1'b0;
                gen_cycle();
                gen_cycle();
                step_v = 1'b1;
                poked  = 1;
            end else begin
                gen_cycle();
            end
        end
        #2 chk("step_done_halted", halted_a, 1);
    endtask

    initial begin
        rst_n = 1'b0; run_q = 1'b0; step_q = 1'b0; cpu_en = 1'b0; sync = 1'b1;
        addr = '0; bp_addr = '0; bp_valid = 1'b0;
        run_v = 1'b0; step_v = 1'b0; bpv_v = 1'b0; bpa_v = '0;
        freeze = 0; want_rdy1 = 0; cyc_clk = 0; cpu_k = 0;
        model_reset();

        //           run step en sync  rdy halt cnt
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1};

        do_reset();

        // Halt on first fetch, then one full step of a 3-cycle instruction
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            run_q  = tbl[i].r;
            step_q = tbl[i].s;
            cpu_en = tbl[i].e;
            sync   = tbl[i].y;
            #1;
            chk($sformatf("tbl%0d_rdy", i), bus_a.rdy, tbl[i].x_rdy);
            chk($sformatf("tbl%0d_halted", i), halted_a, tbl[i].x_halt);
            chk($sformatf("tbl%0d_count", i), cnt_a, tbl[i].x_cnt);
            @(posedge clk);
            model_update();
        end

        run_v = run_q; step_v = step_q; cpu_k = 0; cyc_clk = 0;

        // Two more steps, the second with a step pulse during execution
        do_step(0);
        do_step(1);
        #2 chk("count_after_3_steps", cnt_a, 3);

        // Run request while the step fetch is still pending
        step_v = 1'b0;
        repeat (3) gen_cycle();
        step_v = 1'b1;
        for (int n = 0; n < 100 && m_mode != MD_REL; n++) gen_cycle();
        freeze = 1; run_v = 1'b1; want_rdy1 = 1;
        repeat (6) gen_cycle();
        freeze = 0;
        repeat (10) gen_cycle();
        #2 chk("count_kept_in_run", cnt_a, 3);

        // Breakpoint inputs are inert in this build
        bpv_v = 1'b1; bpa_v = 16'hE000;
        repeat (24) gen_cycle();
        want_rdy1 = 0; bpv_v = 1'b0;

        // Back to halt, then step until the 4-bit counter wraps
        run_v = 1'b0;
        for (int n = 0; n < 100 && m_mode != MD_PARK; n++) gen_cycle();
        #2 chk("halt_after_run", halted_a, 1);
        for (int n = 0; n < 20 && (m_cnt % 16) != 0; n++) do_step(0);
        #2 chk("wrap_w4", cnt_b, 0);
        chk("count16_at_wrap", cnt_a, 16);

        // Random switch activity and breakpoint inputs
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(149, 0) == 0) run_v = ~run_v;
            if ($urandom_range(5, 0) == 0) step_v = ~step_v;
            bpv_v = 1'($urandom);
            bpa_v = ($urandom_range(1, 0) == 0) ? 16'hE000 : 16'($urandom);
            gen_cycle();
        end

        // Reset in the middle of a step
        run_v = 1'b0; bpv_v = 1'b0;
        for (int n = 0; n < 200 && m_mode != MD_PARK; n++) gen_cycle();
        step_v = 1'b0;
        repeat (3) gen_cycle();
        step_v = 1'b1;
        for (int n = 0; n < 200 && m_mode != MD_EXEC; n++) gen_cycle();
        do_reset();
        for (int n = 0; n < 100 && m_mode != MD_PARK; n++) gen_cycle();
        #2 chk("park_after_reset", halted_a, 1);
        chk("count_after_reset", cnt_a, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
